// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared constants and requester state encoding for the
//               4-input fixed-priority bus arbiter and its requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int BUS_DATA_W = 8;
    localparam int BUS_LEN_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } req_state_e;

endpackage

`default_nettype wire

// File: rtl/req_wait_timer.sv
// ============================================================================
// Module      : req_wait_timer
// Description : Load/enable up-counter that raises tc_o once LIMIT cycles
//               have been counted; it then holds until reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_wait_timer #(
    parameter int LIMIT = 15,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count is zero during the first enabled cycle, so tc_o marks the LIMIT-th.
    assign tc_o = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_requester.sv
// ============================================================================
// Module      : bus_requester
// Description : Per-master agent for the fixed-priority bus arbiter: accepts a
//               burst command, requests the bus, streams beats, then releases.
//               Define TIMEOUT_EN to abort requests left ungranted too long.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_requester
    import bus_arb_pkg::*;
#(
    parameter int DATA_W       = BUS_DATA_W,
    parameter int LEN_W        = BUS_LEN_W,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              req,
    input  logic              grant,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              busy,
    output logic              timeout_err
);

    if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
        $error("WAIT_TIMEOUT must be at least 1");
    end

    req_state_e       state_q;
    req_state_e       state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [LEN_W-1:0] beat_cnt_d;
    logic             req_q;
    logic             req_d;
    logic             beat;
    logic             timed_out;

`ifdef TIMEOUT_EN
    logic wait_tc;

    req_wait_timer #(
        .LIMIT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (cmd_valid && (state_q == S_IDLE)),
        .en_i   (state_q == S_REQUEST),
        .tc_o   (wait_tc)
    );

    assign timed_out = (state_q == S_REQUEST) && wait_tc && !grant;
`else
    assign timed_out = 1'b0;
`endif

    // A beat is the client data passed straight through while we own the bus.
    assign beat        = (state_q == S_XFER) && grant && data_valid;
    assign cmd_ready   = (state_q == S_IDLE);
    assign data_ready  = beat;
    assign bus_valid   = beat;
    assign bus_data    = beat ? data_in : '0;
    assign busy        = (state_q != S_IDLE);
    assign req         = req_q;
    assign timeout_err = timed_out;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    state_d    = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (grant) begin
                    state_d = S_XFER;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (beat) begin
                    if (beat_cnt_q == len_q) begin
                        state_d = S_RELEASE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // req is registered from the next state so it drops during RELEASE.
        req_d = (state_d == S_REQUEST) || (state_d == S_XFER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            req_q      <= req_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_requester.sv
// ============================================================================
// Module      : tb_bus_requester
// Description : Directed bench for bus_requester with a beat scoreboard;
//               honours TIMEOUT_EN to select the request-timeout scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_len = 2'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] data_in = 8'h00;
    logic       req;
    logic       grant;
    logic       grant_en = 1'b0;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic       busy;
    logic       timeout_err;

    int         tests = 0;
    int         fails = 0;
    int         beats = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] m_exp;
    logic       dv_en = 1'b1;
    logic       fire  = 1'b0;

    always #5 clk = ~clk;

    // Arbiter stand-in: grant only ever follows our own request.
    assign grant = req & grant_en;

    bus_requester dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_in     (data_in),
        .req         (req),
        .grant       (grant),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Client data source: presents the head of src_q, pops on a consumed beat.
    always @(negedge clk) fire = data_ready;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            data_valid = dv_en && (src_q.size() > 0);
            data_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", bus_data);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("beat_data", bus_data, m_exp);
                end
            end else begin
                check("idle_bus_data", bus_data, 0);
            end
        end
    end

    task automatic issue(input logic [1:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(negedge clk);
        check("cmd_ready_handshake", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beat(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_valid && n < max);
        if (!bus_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_beat: no bus_valid within %0d cycles", max);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        int first;
        int pulses;
        int good;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_bus_data", bus_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_data_ready", data_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 4-beat burst, grant immediate, data always available.
        grant_en = 1'b1;
        dv_en    = 1'b1;
        src_q    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        exp_q    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        b0       = beats;
        issue(2'd3);
        wait_beat(8, n);
        check("A_first_beat_latency", n, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("A_consecutive_beat", bus_valid, 1);
        end
        @(negedge clk);
        check("A_release_req", req, 0);
        check("A_release_busy", busy, 1);
        @(negedge clk);
        check("A_idle_busy", busy, 0);
        check("A_idle_cmd_ready", cmd_ready, 1);
        check("A_beat_count", beats - b0, 4);
        check("A_scoreboard_empty", exp_q.size(), 0);

        // 2-beat burst preempted for 3 cycles; stray command must be ignored.
        src_q = '{8'h11, 8'h22};
        exp_q = '{8'h11, 8'h22};
        b0    = beats;
        issue(2'd1);
        wait_beat(8, n);
        check("B_first_beat_latency", n, 2);
        @(posedge clk); #1;
        grant_en  = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("B_gap_bus_valid", bus_valid, 0);
            check("B_gap_req", req, 1);
            check("B_gap_data_ready", data_ready, 0);
        end
        @(posedge clk); #1;
        grant_en  = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("B_resume_beat", bus_valid, 1);
        @(negedge clk);
        check("B_release_req", req, 0);
        @(negedge clk);
        check("B_idle_busy", busy, 0);
        check("B_beat_count", beats - b0, 2);
        check("B_scoreboard_empty", exp_q.size(), 0);

        // Single beat after a 2-cycle data bubble.
        dv_en = 1'b0;
        src_q = '{8'h5C};
        exp_q = '{8'h5C};
        b0    = beats;
        issue(2'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("C_bubble_bus_valid", bus_valid, 0);
            check("C_bubble_req", req, 1);
        end
        @(posedge clk); #1;
        dv_en = 1'b1;
        @(negedge clk);
        check("C_single_beat", bus_valid, 1);
        @(negedge clk);
        check("C_release_req", req, 0);
        check("C_release_busy", busy, 1);
        @(negedge clk);
        check("C_idle_busy", busy, 0);
        check("C_beat_count", beats - b0, 1);
        check("C_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset after beat 2 of 4.
        src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        exp_q = '{8'hC1, 8'hC2};
        b0    = beats;
        issue(2'd3);
        wait_beat(8, n);
        @(negedge clk);
        check("D_second_beat", bus_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("D_rst_req", req, 0);
        check("D_rst_bus_valid", bus_valid, 0);
        check("D_rst_busy", busy, 0);
        check("D_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        src_q.delete();
        check("D_beat_count", beats - b0, 2);
        check("D_scoreboard_empty", exp_q.size(), 0);

`ifdef TIMEOUT_EN
        // Grant never comes: abort in the 15th REQUEST cycle.
        grant_en = 1'b0;
        issue(2'd0);
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("E_timeout_cycle", first, 15);
        check("E_timeout_pulses", pulses, 1);
        check("E_after_timeout_req", req, 0);
        check("E_after_timeout_busy", busy, 0);
        check("E_after_timeout_cmd_ready", cmd_ready, 1);

        // Grant in the very cycle the timeout would fire: grant wins.
        src_q = '{8'h77};
        exp_q = '{8'h77};
        b0    = beats;
        issue(2'd0);
        repeat (14) @(posedge clk);
        #1;
        grant_en = 1'b1;
        @(negedge clk);
        check("F_no_timeout_err", timeout_err, 0);
        check("F_req_held", req, 1);
        @(negedge clk);
        check("F_beat", bus_valid, 1);
        @(negedge clk);
        @(negedge clk);
        check("F_idle_busy", busy, 0);
        check("F_beat_count", beats - b0, 1);
        check("F_scoreboard_empty", exp_q.size(), 0);
`else
        // Without the timeout the request waits indefinitely.
        grant_en = 1'b0;
        src_q    = '{8'h3C};
        exp_q    = '{8'h3C};
        b0       = beats;
        issue(2'd0);
        good = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req && busy && !timeout_err) good++;
        end
        check("E_wait_100_cycles", good, 100);
        @(posedge clk); #1;
        grant_en = 1'b1;
        wait_beat(8, n);
        check("E_late_grant_latency", n, 2);
        @(negedge clk);
        @(negedge clk);
        check("E_idle_busy", busy, 0);
        check("E_beat_count", beats - b0, 1);
        check("E_scoreboard_empty", exp_q.size(), 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
